// File: rtl/axi_stream_rr_arbiter.sv
// Packet-wise round-robin arbiter: four AXI-Stream-like slaves onto one master.
// A slave holds the grant until its last beat is accepted. One bubble cycle is
// spent in IDLE per packet for arbitration. The master side is a single output
// register that can drain and reload on the same edge.
module axi_stream_rr_arbiter #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           nReset,
    input  logic [4*N-1:0] s_data,
    input  logic [3:0]     s_valid,
    input  logic [3:0]     s_last,
    output logic [3:0]     s_ready,
    output logic [N-1:0]   m_data,
    output logic           m_last,
    output logic [1:0]     m_id,
    output logic           m_valid,
    input  logic           m_ready
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t         state_q, state_d;
    logic [1:0]     g_q, g_d;
    logic [1:0]     ptr_q, ptr_d;
    logic [N-1:0]   m_data_q, m_data_d;
    logic           m_last_q, m_last_d;
    logic [1:0]     m_id_q, m_id_d;
    logic           m_valid_q, m_valid_d;

    logic [N-1:0]   s_data_arr [4];
    logic [1:0]     pick;
    logic           pick_vld;
    logic [1:0]     rr_idx;
    logic           accept;

    for (genvar i = 0; i < 4; i++) begin : g_unpack
        assign s_data_arr[i] = s_data[i*N +: N];
    end

    // Round-robin search from ptr: scan in descending distance so the closest valid slave wins.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        rr_idx   = '0;
        for (int k = 3; k >= 0; k--) begin
            rr_idx = ptr_q + 2'(k);
            if (s_valid[rr_idx]) begin
                pick     = rr_idx;
                pick_vld = 1'b1;
            end
        end
    end

    // State register plus grant owner and round-robin pointer.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= IDLE;
            g_q     <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state: grant on a valid request in IDLE, release after the last beat is accepted.
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    g_d     = pick;
                    ptr_d   = pick + 2'd1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (accept && s_last[g_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs of the FSM: only the granted slave sees ready, gated by output-register space.
    always_comb begin
        s_ready = 4'b0000;
        if (state_q == BUSY) begin
            s_ready[g_q] = ~m_valid_q | m_ready;
        end
    end

    assign accept = s_valid[g_q] & s_ready[g_q];

    // Output register next value: load on accept, otherwise clear valid once drained.
    always_comb begin
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        m_id_d    = m_id_q;
        m_valid_d = m_valid_q;
        if (accept) begin
            m_data_d  = s_data_arr[g_q];
            m_last_d  = s_last[g_q];
            m_id_d    = g_q;
            m_valid_d = 1'b1;
        end else if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    // Output register; reset discards any beat in flight.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            m_id_q    <= '0;
            m_valid_q <= 1'b0;
        end else begin
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
            m_id_q    <= m_id_d;
            m_valid_q <= m_valid_d;
        end
    end

    assign m_data  = m_data_q;
    assign m_last  = m_last_q;
    assign m_id    = m_id_q;
    assign m_valid = m_valid_q;

endmodule

// File: tb/tb_axi_stream_rr_arbiter.sv
// Scoreboard bench for axi_stream_rr_arbiter: per-slave beat queues feed a
// driver, expected master beats are queued by each directed test, and a
// monitor pops and compares on every master handshake.
module tb_axi_stream_rr_arbiter;

    localparam int N = 8;

    typedef struct packed {
        logic [N-1:0] data;
        logic         last;
    } beat_t;

    typedef struct packed {
        logic [1:0]   id;
        logic [N-1:0] data;
        logic         last;
    } exp_t;

    logic           clk;
    logic           nReset;
    logic [4*N-1:0] s_data;
    logic [3:0]     s_valid;
    logic [3:0]     s_last;
    logic [3:0]     s_ready;
    logic [N-1:0]   m_data;
    logic           m_last;
    logic [1:0]     m_id;
    logic           m_valid;
    logic           m_ready;

    beat_t sl_q [4][$];
    exp_t  sb [$];
    int    hs_cyc [$];
    logic [3:0] fire_s;
    int    cyc;
    int    n_pop;
    int    checks;
    int    errors;

    axi_stream_rr_arbiter #(.N(N)) dut (
        .clk     (clk),
        .nReset  (nReset),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_last  (s_last),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_last  (m_last),
        .m_id    (m_id),
        .m_valid (m_valid),
        .m_ready (m_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Slave driver: retire beats handshaken at the last edge, present the next head.
    initial begin
        s_valid = '0;
        s_data  = '0;
        s_last  = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (fire_s[i] && sl_q[i].size() > 0) void'(sl_q[i].pop_front());
                if (sl_q[i].size() > 0) begin
                    s_valid[i]         = 1'b1;
                    s_data[i*N +: N]   = sl_q[i][0].data;
                    s_last[i]          = sl_q[i][0].last;
                end else begin
                    s_valid[i]         = 1'b0;
                    s_data[i*N +: N]   = '0;
                    s_last[i]          = 1'b0;
                end
            end
        end
    end

    // Monitor: sample mid-cycle, compare every master beat that will be taken at the next edge.
    initial begin
        exp_t e;
        fire_s = '0;
        n_pop  = 0;
        forever begin
            @(negedge clk);
            fire_s = s_valid & s_ready;
            if (m_valid && m_ready) begin
                hs_cyc.push_back(cyc);
                n_pop++;
                if (sb.size() == 0) begin
                    chk("unexpected_beat", {22'd0, m_id, m_data}, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("beat_id",   {30'd0, m_id},   {30'd0, e.id});
                    chk("beat_data", {24'd0, m_data}, {24'd0, e.data});
                    chk("beat_last", {31'd0, m_last}, {31'd0, e.last});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input int s, input logic [N-1:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        sl_q[s].push_back(b);
    endtask

    task automatic expect_beat(input int id, input logic [N-1:0] d, input logic l);
        exp_t e;
        e.id   = 2'(id);
        e.data = d;
        e.last = l;
        sb.push_back(e);
    endtask

    function automatic int pending();
        return sb.size() + sl_q[0].size() + sl_q[1].size() + sl_q[2].size() + sl_q[3].size();
    endfunction

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (pending() > 0 && n < budget) begin
            tick();
            n++;
        end
        chk(name, pending(), 0);
        tick();
        tick();
    endtask

    task automatic wait_pops(input string name, input int target, input int budget);
        int n = 0;
        while (n_pop < target && n < budget) begin
            tick();
            n++;
        end
        chk(name, (n_pop >= target) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic gap_check(input string name, input int nbeats, input int gap);
        chk({name, "_count"}, hs_cyc.size(), nbeats);
        for (int i = 1; i < hs_cyc.size(); i++) begin
            chk({name, "_gap"}, hs_cyc[i] - hs_cyc[i-1], gap);
        end
    endtask

    task automatic clear_all();
        for (int i = 0; i < 4; i++) sl_q[i].delete();
        sb.delete();
        hs_cyc.delete();
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_m_valid"}, {31'd0, m_valid}, 0);
        chk({name, "_s_ready"}, {28'd0, s_ready}, 0);
        chk({name, "_m_data"},  {24'd0, m_data},  0);
        chk({name, "_m_id"},    {30'd0, m_id},    0);
        chk({name, "_m_last"},  {31'd0, m_last},  0);
    endtask

    task automatic do_reset();
        nReset = 1'b0;
        tick();
        tick();
        nReset = 1'b1;
        tick();
    endtask

    initial begin
        int base;
        checks  = 0;
        errors  = 0;
        m_ready = 1'b1;
        nReset  = 1'b0;
        #7;
        check_reset_outputs("reset");
        tick();
        nReset = 1'b1;
        tick();

        // Slave 2 two-beat packet, then ptr=3 shows up as slave 3 beating slave 0.
        hs_cyc.delete();
        load(2, 8'h11, 1'b0);
        load(2, 8'h22, 1'b1);
        expect_beat(2, 8'h11, 1'b0);
        expect_beat(2, 8'h22, 1'b1);
        wait_drain("t1_drain", 40);
        load(0, 8'hA5, 1'b1);
        load(3, 8'h3C, 1'b1);
        expect_beat(3, 8'h3C, 1'b1);
        expect_beat(0, 8'hA5, 1'b1);
        wait_drain("t1b_drain", 40);

        // All four slaves with single-beat packets: order 0,1,2,3,0, one beat per 2 cycles.
        do_reset();
        clear_all();
        load(0, 8'hB0, 1'b1);
        load(0, 8'hB4, 1'b1);
        load(1, 8'hB1, 1'b1);
        load(2, 8'hB2, 1'b1);
        load(3, 8'hB3, 1'b1);
        expect_beat(0, 8'hB0, 1'b1);
        expect_beat(1, 8'hB1, 1'b1);
        expect_beat(2, 8'hB2, 1'b1);
        expect_beat(3, 8'hB3, 1'b1);
        expect_beat(0, 8'hB4, 1'b1);
        wait_drain("t2_drain", 60);
        gap_check("t2", 5, 2);

        // Slave 1 stalled by the master for 3 cycles mid-packet.
        do_reset();
        clear_all();
        base = n_pop;
        for (int i = 0; i < 4; i++) begin
            load(1, 8'(8'h31 + i), (i == 3));
            expect_beat(1, 8'(8'h31 + i), (i == 3));
        end
        wait_pops("t3_first_beat", base + 1, 40);
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_stall_valid",  {31'd0, m_valid},    1);
            chk("t3_stall_data",   {24'd0, m_data},     32'h32);
            chk("t3_stall_id",     {30'd0, m_id},       1);
            chk("t3_stall_sready", {31'd0, s_ready[1]}, 0);
        end
        tick();
        m_ready = 1'b1;
        wait_drain("t3_drain", 40);

        // Slave 3 granted; slaves 0 and 1 raise valid mid-packet and wait, then 0 first (ptr wrapped).
        do_reset();
        clear_all();
        base = n_pop;
        for (int i = 0; i < 4; i++) begin
            load(3, 8'(8'h41 + i), (i == 3));
            expect_beat(3, 8'(8'h41 + i), (i == 3));
        end
        expect_beat(0, 8'h51, 1'b1);
        expect_beat(1, 8'h61, 1'b1);
        wait_pops("t4_first_beat", base + 1, 40);
        load(0, 8'h51, 1'b1);
        load(1, 8'h61, 1'b1);
        tick();
        chk("t4_sready_busy", {28'd0, s_ready}, 32'h8);
        wait_drain("t4_drain", 60);

        // Reset pulsed after beat 2 of a 4-beat packet from slave 2.
        do_reset();
        clear_all();
        base = n_pop;
        for (int i = 0; i < 4; i++) begin
            load(2, 8'(8'h71 + i), (i == 3));
            expect_beat(2, 8'(8'h71 + i), (i == 3));
        end
        wait_pops("t5_two_beats", base + 2, 40);
        nReset = 1'b0;
        #1;
        check_reset_outputs("t5_midreset");
        clear_all();
        tick();
        load(3, 8'h91, 1'b1);
        load(1, 8'h81, 1'b1);
        expect_beat(1, 8'h81, 1'b1);
        expect_beat(3, 8'h91, 1'b1);
        tick();
        nReset = 1'b1;
        wait_drain("t5_drain", 40);

        // 8-beat packet from slave 0 at full throughput.
        do_reset();
        clear_all();
        for (int i = 0; i < 8; i++) begin
            load(0, 8'(8'hA0 + i), (i == 7));
            expect_beat(0, 8'(8'hA0 + i), (i == 7));
        end
        wait_drain("t6_drain", 60);
        gap_check("t6", 8, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/axi_stream_rr_arbiter.md
AXI_STREAM_RR_ARBITER -- requirements
Module: axi_stream_rr_arbiter

Interface
REQ-001 The module SHALL have parameter N, default 8, meaning data width in bits of every stream.
REQ-002 The module SHALL have port clk, input, 1 bit: single clock; all logic on the rising edge.
REQ-003 The module SHALL have port nReset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port s_data, input, 4*N bits: slave data; bits [i*N+N-1:i*N] belong to slave i (i=0..3).
REQ-005 The module SHALL have port s_valid, input, 4 bits: per-slave valid.
REQ-006 The module SHALL have port s_last, input, 4 bits: per-slave end-of-packet flag.
REQ-007 The module SHALL have port s_ready, output, 4 bits: per-slave ready.
REQ-008 The module SHALL have port m_data, output, N bits: master data.
REQ-009 The module SHALL have port m_last, output, 1 bit: master end-of-packet flag.
REQ-010 The module SHALL have port m_id, output, 2 bits: index of the slave that sourced the current master beat.
REQ-011 The module SHALL have port m_valid, output, 1 bit: master valid.
REQ-012 The module SHALL have port m_ready, input, 1 bit: master ready.

Function
REQ-013 The module SHALL arbitrate packet-wise among 4 slave streams onto 1 master stream; a granted slave keeps the grant until its beat with s_last=1 is accepted.
REQ-014 FSM SHALL have two states: IDLE (no grant) and BUSY (grant held by slave g, a 2-bit register).
REQ-015 In IDLE with s_valid!=0, the module SHALL select the first i with s_valid[i]=1, searching ptr, ptr+1, ..., ptr+3 (mod 4), load g=i, set ptr=(i+1) mod 4 and enter BUSY on the next edge.
REQ-016 In IDLE with s_valid=0, the module SHALL stay in IDLE with g and ptr unchanged.
REQ-017 In IDLE, s_ready SHALL be 4'b0000; no beat is accepted in the arbitration cycle (1-cycle bubble per packet).
REQ-018 In BUSY, s_ready[g] SHALL equal (~m_valid | m_ready) combinationally; all other s_ready bits SHALL be 0.
REQ-019 A slave beat SHALL be accepted when s_valid[g] & s_ready[g]; it SHALL load m_data, m_last, m_id=g and set m_valid=1 on that edge (latency 1 cycle input-to-output).
REQ-020 When m_valid & m_ready and no beat is accepted on the same edge, m_valid SHALL clear to 0.
REQ-021 Simultaneous master drain and slave accept SHALL replace the output register with the new beat and keep m_valid=1 (full throughput, one beat per cycle inside a packet).
REQ-022 While m_valid=1 and m_ready=0, m_data, m_last and m_id SHALL hold stable.
REQ-023 Acceptance of a beat with s_last[g]=1 SHALL move the FSM to IDLE on that edge; the next arbitration SHALL occur in the following cycle, regardless of whether the master has drained that beat.
REQ-024 s_valid on non-granted slaves SHALL be ignored during BUSY; changes to s_valid[g] while s_ready[g]=0 SHALL have no effect.
REQ-025 A single-beat packet (s_last=1 on the first beat) SHALL occupy exactly 2 cycles of the arbiter at m_ready=1: one IDLE and one BUSY.
REQ-026 ptr SHALL wrap from 3 to 0; a slave just served SHALL have lowest priority at the next arbitration.

Reset
REQ-027 On nReset=0, asynchronously: state=IDLE, g=0, ptr=0, m_valid=0, m_last=0, m_id=0, m_data=0, s_ready=4'b0000.
REQ-028 Reset asserted mid-packet SHALL discard the output beat and partial packet; after release, arbitration SHALL restart from ptr=0.
REQ-029 Deassertion of nReset SHALL be treated by the integrator as synchronous to clk; the first arbitration SHALL occur on the first edge with nReset=1.

Verification
REQ-030 Reset, then s_valid=4'b0100, slave 2 sends beats 0x11, 0x22(last) with m_ready=1 -> m_id=2, m_data 0x11 then 0x22, m_last=1 on second beat, ptr=3 afterwards.
REQ-031 All four slaves valid with 1-beat packets, m_ready=1 -> grant order 0,1,2,3,0 and m_valid duty of one beat every 2 cycles.
REQ-032 Slave 1 mid-packet, m_ready=0 for 3 cycles -> m_data/m_id stable, s_ready[1]=0 while m_valid=1, no beat lost or duplicated after m_ready returns.
REQ-033 Slave 3 granted, slave 0 raises s_valid mid-packet -> slave 0 waits until slave 3's last beat is accepted, then granted (ptr wrapped to 0).
REQ-034 nReset pulsed low during a 4-beat packet after beat 2 -> m_valid=0 and s_ready=0 immediately, next packet from lowest-index valid slave starting at ptr=0.
REQ-035 Back-to-back beats with m_ready=1 inside an 8-beat packet -> 8 consecutive m_valid cycles, data in order, m_last only on beat 8.
